// File: rtl/timer_arb_pkg.sv
// Shared definitions for the shared interval-timer arbiter: FSM states and widths.
package timer_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int CNT_W_DEF = 32;
  localparam int STAT_W    = 16;

endpackage

// File: rtl/shared_timer_arb_rr_pick.sv
// Combinational round-robin finder: first set req bit scanning upward from ptr+1 with wrap.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IDX_W-1:0]   idx,
  output logic               found
);

  always_comb begin
    int j;
    j      = 0;
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    // The last candidate visited (k == NUM_REQ) is ptr itself, so it has lowest priority.
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = (int'(ptr) + k) % NUM_REQ;
      if (!found && req[j]) begin
        found     = 1'b1;
        onehot[j] = 1'b1;
        idx       = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/shared_timer_arb.sv
// One up-counting interval timer shared round-robin among NUM_REQ requesters.
// Optional macro TIMER_ARB_STAT_EN adds saturating per-requester completion counters (stat_cnt).
module shared_timer_arb
  import timer_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*CNT_W-1:0]   dur,
  input  logic                       abort,
  output logic [NUM_REQ-1:0]         grant,
  output logic                       busy,
  output logic [NUM_REQ-1:0]         done,
  output logic [CNT_W-1:0]           count
`ifdef TIMER_ARB_STAT_EN
  ,
  output logic [NUM_REQ*STAT_W-1:0]  stat_cnt
`endif
);

  localparam int IDX_W = $clog2(NUM_REQ);

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic                 busy_q, busy_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [CNT_W-1:0]     target_q, target_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [IDX_W-1:0]     owner_q, owner_d;

  logic [NUM_REQ-1:0]   pick_oh;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_found;
  logic [CNT_W-1:0]     dur_sel;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req    (req),
    .ptr    (ptr_q),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .found  (pick_found)
  );

  assign dur_sel = dur[int'(pick_idx)*CNT_W +: CNT_W];

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    done_d   = '0;
    busy_d   = busy_q;
    count_d  = count_q;
    target_d = target_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d  = RUN;
          grant_d  = pick_oh;
          owner_d  = pick_idx;
          // A zero duration still runs one cycle so the owner always sees a done.
          target_d = (dur_sel == '0) ? CNT_W'(1) : dur_sel;
          count_d  = '0;
          busy_d   = 1'b1;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          grant_d = '0;
          count_d = '0;
          busy_d  = 1'b0;
          ptr_d   = owner_q;
        end else if (count_q == target_q - CNT_W'(1)) begin
          state_d = DONE;
          grant_d = '0;
          done_d  = grant_q;
          ptr_d   = owner_q;
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        count_d = '0;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      done_q   <= '0;
      busy_q   <= 1'b0;
      count_q  <= '0;
      target_q <= '0;
      ptr_q    <= IDX_W'(NUM_REQ - 1);
      owner_q  <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      count_q  <= count_d;
      target_q <= target_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
    end
  end

  assign grant = grant_q;
  assign done  = done_q;
  assign busy  = busy_q;
  assign count = count_q;

`ifdef TIMER_ARB_STAT_EN
  logic [NUM_REQ*STAT_W-1:0] stat_q, stat_d;

  // Counters advance on the same edge that raises done, saturating at all-ones.
  always_comb begin
    stat_d = stat_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (done_d[i] && (stat_q[i*STAT_W +: STAT_W] != {STAT_W{1'b1}})) begin
        stat_d[i*STAT_W +: STAT_W] = stat_q[i*STAT_W +: STAT_W] + STAT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_q <= '0;
    end else begin
      stat_q <= stat_d;
    end
  end

  assign stat_cnt = stat_q;
`endif

endmodule

// File: tb/tb_shared_timer_arb.sv
// Scoreboard bench for shared_timer_arb: a timeline model predicts each cycle's outputs.
module tb_shared_timer_arb;

  localparam int N  = 4;
  localparam int CW = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N*CW-1:0] dur = '0;
  logic            abort = 1'b0;
  logic [N-1:0]    grant;
  logic            busy;
  logic [N-1:0]    done;
  logic [CW-1:0]   count;
`ifdef TIMER_ARB_STAT_EN
  logic [N*16-1:0] stat_cnt;
`endif

  shared_timer_arb #(.NUM_REQ(N), .CNT_W(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .dur      (dur),
    .abort    (abort),
    .grant    (grant),
    .busy     (busy),
    .done     (done),
    .count    (count)
`ifdef TIMER_ARB_STAT_EN
    ,
    .stat_cnt (stat_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]    grant;
    logic [N-1:0]    done;
    logic            busy;
    logic [CW-1:0]   count;
    logic [N*16-1:0] stat;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Timeline model: a grant at edge g with length t shows grant for edges g..g+t-1,
  // done at g+t, and the next arbitration happens at edge g+t+2 (abort at edge a: a+1).
  int  n, next_arb, g, tgt, owner, mptr;
  bit  active;
  int  stat_m[N];

  always @(posedge clk) begin
    exp_t e;
    if (rst) begin
      n = 0; next_arb = 1; active = 0; mptr = N - 1; g = 0; tgt = 0; owner = 0;
      for (int i = 0; i < N; i++) stat_m[i] = 0;
    end else begin
      n++;
      if (active && n >= g + 1 && n <= g + tgt && abort) begin
        active = 0; mptr = owner; next_arb = n + 1;
      end else if (active && n > g + tgt) begin
        active = 0;
      end
      if (!active && n >= next_arb && req != '0) begin
        for (int k = 1; k <= N; k++) begin
          int j;
          j = (mptr + k) % N;
          if (!active && req[j]) begin
            owner = j; g = n; active = 1;
            tgt = (dur[j*CW +: CW] == 0) ? 1 : int'(dur[j*CW +: CW]);
            next_arb = g + tgt + 2;
          end
        end
      end
      e.grant = '0; e.done = '0; e.busy = 1'b0; e.count = '0;
      if (active) begin
        e.busy = (n <= g + tgt);
        if (n < g + tgt) begin
          e.grant = N'(1) << owner;
          e.count = CW'(n - g);
        end else if (n == g + tgt) begin
          e.done = N'(1) << owner;
          e.count = CW'(tgt - 1);
          mptr = owner;
          if (stat_m[owner] < 16'hFFFF) stat_m[owner]++;
        end
      end
      for (int i = 0; i < N; i++) e.stat[i*16 +: 16] = 16'(stat_m[i]);
      exp_q.push_back(e);
    end
  end

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("grant", 64'(grant), 64'(e.grant));
      check("done",  64'(done),  64'(e.done));
      check("busy",  64'(busy),  64'(e.busy));
      check("count", 64'(count), 64'(e.count));
`ifdef TIMER_ARB_STAT_EN
      check("stat_cnt", stat_cnt[63:0], e.stat[63:0]);
`endif
    end
  end

  task automatic drive(input logic [N-1:0] r, input int d0, input int d1,
                       input int d2, input int d3, input logic ab);
    @(negedge clk);
    req = r; abort = ab;
    dur = {CW'(d3), CW'(d2), CW'(d1), CW'(d0)};
  endtask

  task automatic idle_cycles(input int c);
    for (int i = 0; i < c; i++) drive('0, 0, 0, 0, 0, 1'b0);
  endtask

  task automatic wait_count(input logic [CW-1:0] v, input int budget, input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(posedge clk); #1;
      if (count == v && grant != '0) ok = 1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: count never reached %0d within %0d cycles", name, v, budget);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_grant"}, 64'(grant), 64'd0);
    check({tag, "_done"},  64'(done),  64'd0);
    check({tag, "_busy"},  64'(busy),  64'd0);
    check({tag, "_count"}, 64'(count), 64'd0);
  endtask

  initial begin
    #1;
    check_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;

    // Single request, duration 3
    drive(4'b0001, 3, 0, 0, 0, 1'b0);
    idle_cycles(8);
    // Contention, all durations 2
    for (int i = 0; i < 22; i++) drive(4'b1111, 2, 2, 2, 2, 1'b0);
    idle_cycles(6);
    // Zero duration
    drive(4'b0010, 0, 0, 0, 0, 1'b0);
    idle_cycles(5);

    // Abort at count 4, then requester 1 should win after wrapping past 3 and 0
    drive(4'b0100, 0, 0, 10, 0, 1'b0);
    wait_count(32'd4, 20, "abort_wait");
    drive(4'b0110, 0, 5, 10, 0, 1'b1);
    drive(4'b0110, 0, 5, 10, 0, 1'b0);
    @(posedge clk); #1;
    check("abort_next_grant", 64'(grant), 64'b0010);
    idle_cycles(10);

    // Asynchronous reset mid-interval
    drive(4'b0001, 100, 0, 0, 0, 1'b0);
    wait_count(32'd50, 80, "rst_wait");
    rst = 1'b1;
    #1;
    check_zero("midrst");
    drive(4'b0101, 4, 0, 4, 0, 1'b0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("rst_next_grant", 64'(grant), 64'b0001);
    idle_cycles(12);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      logic [N-1:0] r;
      r = N'($urandom_range(0, 15));
      drive(r, $urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 6),
            $urandom_range(0, 6), ($urandom_range(0, 11) == 0));
    end
    idle_cycles(12);
    @(posedge clk); #2;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
